// File: rtl/pipeline_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
//   Bundles the hazard-detection inputs coming from the datapath and the
//   enable/flush strobes that go back to the pipeline registers.
//   Ports carried:
//     id_rs1, id_rs2, ex_rd  register numbers used for load-use detection
//     ex_mem_read            instruction in EX is a load
//     branch_taken           branch/jump resolved taken in EX
//     mem_req, mem_ready     data-memory access handshake of the MEM stage
//     pc_en, if_id_en, if_id_flush, id_ex_flush,
//     ex_mem_en, mem_wb_en, mem_wb_bubble   pipeline register strobes
//     mem_err                sticky memory-timeout flag
//     stall_count            saturating count of cycles with pc_en=0
//   Modports:
//     master  datapath side (drives hazard inputs, receives strobes)
//     slave   hazard controller side
// ----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             mem_wb_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, branch_taken, mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en,
           mem_wb_bubble, mem_err, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, branch_taken, mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, mem_wb_en,
           mem_wb_bubble, mem_err, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
//   registers. Detects load-use hazards and taken branches, freezes the
//   pipeline while data memory is not ready, and latches a sticky error when
//   a memory access waits MEM_TIMEOUT consecutive cycles.
//   Parameters:
//     MEM_TIMEOUT  consecutive wait cycles before the sticky error (>=2)
//     CNT_W        width of stall_count
//   Ports:
//     clock        rising-edge system clock
//     reset        synchronous, active-high
//     hz           hazard interface (slave modport): hazard inputs in,
//                  register strobes / mem_err / stall_count out
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  state_t             state_reg;
  state_t             state_next;
  logic [WAIT_W-1:0]  wait_cnt_reg;
  logic [WAIT_W-1:0]  wait_cnt_next;
  logic               mem_err_reg;
  logic               mem_err_next;
  logic [CNT_W-1:0]   stall_count_reg;

  logic mstall;
  logic luse;

  logic pc_en_c;
  logic if_id_en_c;
  logic if_id_flush_c;
  logic id_ex_flush_c;
  logic ex_mem_en_c;
  logic mem_wb_en_c;
  logic mem_wb_bubble_c;

  assign mstall = hz.mem_req & ~hz.mem_ready;
  // Register x0 is hard-wired zero, so a load "into" it never creates a hazard.
  assign luse   = hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                  ((hz.ex_rd == hz.id_rs1) | (hz.ex_rd == hz.id_rs2));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= S_RUN;
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_err_next  = mem_err_reg;
    case (state_reg)
      S_RUN: begin
        if (mstall) begin
          state_next    = S_MEM_WAIT;
          // The entering cycle is itself the first wait cycle.
          wait_cnt_next = WAIT_W'(1);
        end
      end
      S_MEM_WAIT: begin
        if (mstall) begin
          if (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_next   = S_ERR;
            mem_err_next = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
          end
        end else begin
          state_next    = S_RUN;
          wait_cnt_next = '0;
        end
      end
      S_ERR: begin
        // Terminal until reset.
      end
      default: begin
        state_next    = S_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: strobes are combinational from state and current inputs.
  // MEM_WAIT without mstall is the release cycle, so branch/load-use are
  // evaluated exactly as in RUN.
  // --------------------------------------------------------------------------
  always_comb begin
    pc_en_c         = 1'b1;
    if_id_en_c      = 1'b1;
    if_id_flush_c   = 1'b0;
    id_ex_flush_c   = 1'b0;
    ex_mem_en_c     = 1'b1;
    mem_wb_en_c     = 1'b1;
    mem_wb_bubble_c = 1'b0;
    if (reset) begin
      pc_en_c         = 1'b0;
      if_id_en_c      = 1'b0;
      ex_mem_en_c     = 1'b0;
      mem_wb_en_c     = 1'b0;
      if_id_flush_c   = 1'b1;
      id_ex_flush_c   = 1'b1;
      mem_wb_bubble_c = 1'b1;
    end else if (state_reg == S_ERR) begin
      pc_en_c         = 1'b0;
      if_id_en_c      = 1'b0;
      ex_mem_en_c     = 1'b0;
      mem_wb_en_c     = 1'b0;
      mem_wb_bubble_c = 1'b1;
    end else if (mstall) begin
      // Front of the pipe holds; MEM/WB keeps loading a bubble so the
      // instruction already in WB is not retired a second time.
      pc_en_c         = 1'b0;
      if_id_en_c      = 1'b0;
      ex_mem_en_c     = 1'b0;
      mem_wb_bubble_c = 1'b1;
    end else if (hz.branch_taken) begin
      if_id_flush_c   = 1'b1;
      id_ex_flush_c   = 1'b1;
    end else if (luse) begin
      pc_en_c         = 1'b0;
      if_id_en_c      = 1'b0;
      id_ex_flush_c   = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Stall-cycle counter, saturating at all-ones.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count_reg <= '0;
    end else if (!pc_en_c && (stall_count_reg != {CNT_W{1'b1}})) begin
      stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign hz.pc_en         = pc_en_c;
  assign hz.if_id_en      = if_id_en_c;
  assign hz.if_id_flush   = if_id_flush_c;
  assign hz.id_ex_flush   = id_ex_flush_c;
  assign hz.ex_mem_en     = ex_mem_en_c;
  assign hz.mem_wb_en     = mem_wb_en_c;
  assign hz.mem_wb_bubble = mem_wb_bubble_c;
  assign hz.mem_err       = mem_err_reg;
  assign hz.stall_count   = stall_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Two controller instances (CNT_W=16 and CNT_W=2) see identical stimulus.
//   A reference model tracks "consecutive stalled memory cycles", an error
//   flag and the saturating stall totals, and a compare process checks every
//   output of both instances on each falling edge. Directed sequences add
//   hand-computed literal expectations, followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;

  logic clock;
  logic reset;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  // reference model state
  bit m_err;
  int m_consec;
  int m_cnt;
  int m_cnt_s;

  pipeline_hazard_ctrl_if #(.CNT_W(16)) hz   ();
  pipeline_hazard_ctrl_if #(.CNT_W(2))  hz_s ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz)
  );

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(2)) dut_s (
    .clock (clock),
    .reset (reset),
    .hz    (hz_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic mr, input logic br, input logic req, input logic rdy);
    hz.id_rs1 = rs1;   hz_s.id_rs1 = rs1;
    hz.id_rs2 = rs2;   hz_s.id_rs2 = rs2;
    hz.ex_rd = rd;     hz_s.ex_rd = rd;
    hz.ex_mem_read = mr;  hz_s.ex_mem_read = mr;
    hz.branch_taken = br; hz_s.branch_taken = br;
    hz.mem_req = req;     hz_s.mem_req = req;
    hz.mem_ready = rdy;   hz_s.mem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Per-cycle compare against the model, then advance the model to the
  // values the upcoming rising edge must produce.
  // --------------------------------------------------------------------------
  always @(negedge clock) begin
    if (cmp_on) begin
      bit ms, lu;
      bit e_pc, e_ifen, e_iff, e_idf, e_exen, e_wben, e_bub;
      ms = hz.mem_req && !hz.mem_ready;
      lu = hz.ex_mem_read && (hz.ex_rd != 0) &&
           (hz.ex_rd == hz.id_rs1 || hz.ex_rd == hz.id_rs2);
      // default: everything advances
      {e_pc, e_ifen, e_iff, e_idf, e_exen, e_wben, e_bub} = 7'b1100110;
      if (reset)           {e_pc, e_ifen, e_iff, e_idf, e_exen, e_wben, e_bub} = 7'b0011001;
      else if (m_err)      {e_pc, e_ifen, e_iff, e_idf, e_exen, e_wben, e_bub} = 7'b0000001;
      else if (ms)         {e_pc, e_ifen, e_iff, e_idf, e_exen, e_wben, e_bub} = 7'b0000011;
      else if (hz.branch_taken)
                           {e_pc, e_ifen, e_iff, e_idf, e_exen, e_wben, e_bub} = 7'b1111110;
      else if (lu)         {e_pc, e_ifen, e_iff, e_idf, e_exen, e_wben, e_bub} = 7'b0001110;

      chk("pc_en",         32'(hz.pc_en),         32'(e_pc));
      chk("if_id_en",      32'(hz.if_id_en),      32'(e_ifen));
      chk("if_id_flush",   32'(hz.if_id_flush),   32'(e_iff));
      chk("id_ex_flush",   32'(hz.id_ex_flush),   32'(e_idf));
      chk("ex_mem_en",     32'(hz.ex_mem_en),     32'(e_exen));
      chk("mem_wb_en",     32'(hz.mem_wb_en),     32'(e_wben));
      chk("mem_wb_bubble", 32'(hz.mem_wb_bubble), 32'(e_bub));
      chk("mem_err",       32'(hz.mem_err),       32'(m_err));
      chk("stall_count",   32'(hz.stall_count),   32'(m_cnt));
      chk("small_pc_en",   32'(hz_s.pc_en),       32'(e_pc));
      chk("small_mem_err", 32'(hz_s.mem_err),     32'(m_err));
      chk("small_stall_count", 32'(hz_s.stall_count), 32'(m_cnt_s));

      if (reset) begin
        m_err = 1'b0; m_consec = 0; m_cnt = 0; m_cnt_s = 0;
      end else begin
        if (!e_pc) begin
          if (m_cnt < 65535) m_cnt++;
          if (m_cnt_s < 3)   m_cnt_s++;
        end
        if (!m_err) begin
          if (ms) begin
            m_consec++;
            if (m_consec >= MEM_TIMEOUT) m_err = 1'b1;
          end else begin
            m_consec = 0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    m_err = 1'b0; m_consec = 0; m_cnt = 0; m_cnt_s = 0;
    reset = 1'b1;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    cmp_on = 1'b1;
    #1;
    chk("rst_pc_en", 32'(hz.pc_en), 32'd0);
    chk("rst_if_id_flush", 32'(hz.if_id_flush), 32'd1);
    chk("rst_id_ex_flush", 32'(hz.id_ex_flush), 32'd1);
    chk("rst_mem_wb_bubble", 32'(hz.mem_wb_bubble), 32'd1);
    chk("rst_mem_wb_en", 32'(hz.mem_wb_en), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_stall_count", 32'(hz.stall_count), 32'd0);
    chk("rst_mem_err", 32'(hz.mem_err), 32'd0);
    chk("run_pc_en", 32'(hz.pc_en), 32'd1);

    // load-use on rs2
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("luse_pc_en", 32'(hz.pc_en), 32'd0);
    chk("luse_if_id_en", 32'(hz.if_id_en), 32'd0);
    chk("luse_id_ex_flush", 32'(hz.id_ex_flush), 32'd1);
    chk("luse_ex_mem_en", 32'(hz.ex_mem_en), 32'd1);
    tick();
    chk("luse_stall_count", 32'(hz.stall_count), 32'd1);

    // x0 destination never stalls
    drive(5'd0, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    chk("x0_pc_en", 32'(hz.pc_en), 32'd1);
    chk("x0_if_id_en", 32'(hz.if_id_en), 32'd1);
    chk("x0_id_ex_flush", 32'(hz.id_ex_flush), 32'd0);
    tick();

    // branch overrides load-use
    drive(5'd1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    #1;
    chk("br_if_id_flush", 32'(hz.if_id_flush), 32'd1);
    chk("br_id_ex_flush", 32'(hz.id_ex_flush), 32'd1);
    chk("br_pc_en", 32'(hz.pc_en), 32'd1);
    tick();
    chk("br_stall_count", 32'(hz.stall_count), 32'd1);

    // three wait cycles then ready
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_pc_en", 32'(hz.pc_en), 32'd0);
      chk("mw_mem_wb_bubble", 32'(hz.mem_wb_bubble), 32'd1);
      chk("mw_mem_wb_en", 32'(hz.mem_wb_en), 32'd1);
      tick();
    end
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    chk("mw_release_pc_en", 32'(hz.pc_en), 32'd1);
    chk("mw_release_bubble", 32'(hz.mem_wb_bubble), 32'd0);
    tick();
    chk("mw_stall_count", 32'(hz.stall_count), 32'd4);
    chk("small_sat_count", 32'(hz_s.stall_count), 32'd3);

    // timeout after 16 consecutive wait cycles
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) tick();
    chk("to_mem_err_early", 32'(hz.mem_err), 32'd0);
    tick();
    chk("to_mem_err", 32'(hz.mem_err), 32'd1);
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("err_pc_en", 32'(hz.pc_en), 32'd0);
    chk("err_mem_wb_en", 32'(hz.mem_wb_en), 32'd0);
    chk("err_bubble", 32'(hz.mem_wb_bubble), 32'd1);
    tick();
    tick();
    chk("err_stall_count", 32'(hz.stall_count), 32'd22);
    chk("err_small_count", 32'(hz_s.stall_count), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("clr_mem_err", 32'(hz.mem_err), 32'd0);
    chk("clr_stall_count", 32'(hz.stall_count), 32'd0);
    chk("clr_small_count", 32'(hz_s.stall_count), 32'd0);
    chk("clr_pc_en", 32'(hz.pc_en), 32'd1);

    // reset in the middle of a memory wait
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("midrst_pc_en", 32'(hz.pc_en), 32'd1);
    chk("midrst_stall_count", 32'(hz.stall_count), 32'd0);
    tick();

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      if ((n % 700) == 350) begin
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 20; k++) tick();
      end
      reset = ($urandom_range(0, 99) == 0);
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 7));
      tick();
    end
    reset = 1'b0;
    @(negedge clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
